// File: rtl/fft_iter_pkg.sv
// Shared state encoding and parameter helpers for the iterative FFT scheduler.
package fft_iter_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        EXE  = 3'd2,
        WB   = 3'd3,
        FIN  = 3'd4
    } fft_state_e;

    localparam int CycWL = 3;

    function automatic bit but_clk_cycle_legal(input int cycles);
        return (cycles >= 1) && (cycles <= 4);
    endfunction

endpackage

// File: rtl/fft_iter_loop_counter.sv
// Nested butterfly/layer counter: butterflies roll into the next layer and
// the pair parks on the final butterfly of the final layer until cleared.
module fft_iter_loop_counter
    import fft_iter_pkg::*;
#(
    parameter int LAYERS      = 5,
    parameter int BUTTERFLYES = 16,
    parameter int LayWL       = 4,
    parameter int ButtWL      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    output logic [LayWL-1:0] lay_cnt,
    output logic             but_last,
    output logic             lay_last,
    output logic             lay_adv
);

    logic [ButtWL-1:0] but_cnt_r;
    logic [LayWL-1:0]  lay_cnt_r;

    // Counter update: clear wins, then a step advances the nested pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            but_cnt_r <= {ButtWL{1'b0}};
            lay_cnt_r <= {LayWL{1'b0}};
        end else if (clr) begin
            but_cnt_r <= {ButtWL{1'b0}};
            lay_cnt_r <= {LayWL{1'b0}};
        end else if (step) begin
            if (!but_last) begin
                but_cnt_r <= but_cnt_r + ButtWL'(1'b1);
            end else if (!lay_last) begin
                but_cnt_r <= {ButtWL{1'b0}};
                lay_cnt_r <= lay_cnt_r + LayWL'(1'b1);
            end
        end
    end

    assign but_last = (but_cnt_r == ButtWL'(BUTTERFLYES - 1));
    assign lay_last = (lay_cnt_r == LayWL'(LAYERS - 1));
    assign lay_adv  = step & but_last;
    assign lay_cnt  = lay_cnt_r;

endmodule

// File: rtl/fft_iter_layer_scheduler.sv
// Moore sequencer stepping the radix-2 butterfly datapath through every
// butterfly of every layer: read, execute, write back, then finish.
module fft_iter_layer_scheduler
    import fft_iter_pkg::*;
#(
    parameter int LAYERS        = 5,
    parameter int BUTTERFLYES   = 16,
    parameter int LayWL         = 4,
    parameter int ButtWL        = 4,
    parameter int BUT_CLK_CYCLE = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic START,
    input  logic ABORT,
    output logic BUSY,
    output logic DONE,
    output logic BUT_STROB,
    output logic ADDR_EN,
    output logic LAY_EN,
    output logic ADDR_RST,
    output logic RAM_EN_R,
    output logic RAM_EN_WR,
    output logic WR,
    output logic FIRST_LAY,
    output logic LAST_LAY
);

    // An out-of-range latency collapses to a single execute cycle.
    localparam bit CycOk = but_clk_cycle_legal(BUT_CLK_CYCLE);
    localparam logic [CycWL-1:0] CycLast = CycWL'(CycOk ? BUT_CLK_CYCLE - 1 : 0);

    fft_state_e        state_r;
    logic [CycWL-1:0]  cyc_cnt_r;
    logic              abort_s;
    logic              step_s;
    logic              clr_s;
    logic [LayWL-1:0]  lay_cnt_s;
    logic              but_last_s;
    logic              lay_last_s;
    logic              lay_adv_s;

    assign abort_s = ABORT && (state_r != IDLE);
    assign step_s  = EN && (state_r == WB);
    assign clr_s   = abort_s || (EN && (state_r == FIN));

    fft_iter_loop_counter #(
        .LAYERS      (LAYERS),
        .BUTTERFLYES (BUTTERFLYES),
        .LayWL       (LayWL),
        .ButtWL      (ButtWL)
    ) u_loop_counter (
        .clk      (CLK),
        .rst_n    (RST),
        .clr      (clr_s),
        .step     (step_s),
        .lay_cnt  (lay_cnt_s),
        .but_last (but_last_s),
        .lay_last (lay_last_s),
        .lay_adv  (lay_adv_s)
    );

    // Sequencer: abort overrides everything, EN low freezes state and cycle count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= IDLE;
            cyc_cnt_r <= {CycWL{1'b0}};
        end else if (abort_s) begin
            state_r   <= IDLE;
            cyc_cnt_r <= {CycWL{1'b0}};
        end else if (EN) begin
            case (state_r)
                IDLE: begin
                    if (START) begin
                        state_r <= RD;
                    end
                end
                RD: begin
                    state_r   <= EXE;
                    cyc_cnt_r <= {CycWL{1'b0}};
                end
                EXE: begin
                    cyc_cnt_r <= cyc_cnt_r + CycWL'(1'b1);
                    if (cyc_cnt_r == CycLast) begin
                        state_r <= WB;
                    end
                end
                WB: begin
                    state_r <= (but_last_s && lay_last_s) ? FIN : RD;
                end
                FIN: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    cyc_cnt_r <= {CycWL{1'b0}};
                end
            endcase
        end
    end

    assign BUSY      = (state_r != IDLE);
    assign ADDR_RST  = (state_r == IDLE);
    assign DONE      = EN && (state_r == FIN);
    assign RAM_EN_R  = EN && (state_r == RD);
    assign BUT_STROB = EN && (state_r == EXE) && (cyc_cnt_r == {CycWL{1'b0}});
    assign ADDR_EN   = step_s;
    assign RAM_EN_WR = step_s;
    assign WR        = step_s;
    assign LAY_EN    = lay_adv_s;
    assign FIRST_LAY = BUSY && (lay_cnt_s == {LayWL{1'b0}});
    assign LAST_LAY  = BUSY && lay_last_s;

endmodule

// File: tb/tb_fft_iter_layer_scheduler.sv
// Randomized self-checking bench for fft_iter_layer_scheduler against a
// cycle-index reference model of the butterfly schedule.
module tb_fft_iter_layer_scheduler;

    localparam int L0 = 3;
    localparam int B0 = 4;
    localparam int C0 = 3;
    localparam int T0 = L0 * B0 * (C0 + 2) + 1;

    logic CLK, RST, EN, START, ABORT, start_sw;
    logic BUSY, DONE, BUT_STROB, ADDR_EN, LAY_EN, ADDR_RST;
    logic RAM_EN_R, RAM_EN_WR, WR, FIRST_LAY, LAST_LAY;
    logic [2:0] sw_busy, sw_done, sw_strob, sw_addr_en, sw_lay_en, sw_addr_rst;
    logic [2:0] sw_ram_r, sw_ram_wr, sw_wr, sw_first, sw_last;

    int n_tests, n_fail, cyc, t_m, trace_err, bad_cyc;
    logic [10:0] bad_o, bad_e;
    int cnt_strob, cnt_addr, cnt_wr, cnt_lay, cnt_done, off_strobe, done_cyc, run_a;
    bit done_seen;
    int done_q[$];
    logic ll_hist [0:255];

    fft_iter_layer_scheduler #(
        .LAYERS(L0), .BUTTERFLYES(B0), .LayWL(2), .ButtWL(2), .BUT_CLK_CYCLE(C0)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START), .ABORT(ABORT),
        .BUSY(BUSY), .DONE(DONE), .BUT_STROB(BUT_STROB), .ADDR_EN(ADDR_EN),
        .LAY_EN(LAY_EN), .ADDR_RST(ADDR_RST), .RAM_EN_R(RAM_EN_R),
        .RAM_EN_WR(RAM_EN_WR), .WR(WR), .FIRST_LAY(FIRST_LAY), .LAST_LAY(LAST_LAY)
    );

    function automatic int sw_c(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_sw
        fft_iter_layer_scheduler #(
            .LAYERS(5), .BUTTERFLYES(16), .LayWL(4), .ButtWL(4),
            .BUT_CLK_CYCLE((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_sw (
            .CLK(CLK), .RST(RST), .EN(1'b1), .START(start_sw), .ABORT(1'b0),
            .BUSY(sw_busy[g]), .DONE(sw_done[g]), .BUT_STROB(sw_strob[g]),
            .ADDR_EN(sw_addr_en[g]), .LAY_EN(sw_lay_en[g]), .ADDR_RST(sw_addr_rst[g]),
            .RAM_EN_R(sw_ram_r[g]), .RAM_EN_WR(sw_ram_wr[g]), .WR(sw_wr[g]),
            .FIRST_LAY(sw_first[g]), .LAST_LAY(sw_last[g])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected outputs for enabled-cycle index t after START acceptance (0 = idle).
    // Bit order: BUSY DONE BUT_STROB ADDR_EN LAY_EN ADDR_RST RAM_EN_R RAM_EN_WR WR FIRST_LAY LAST_LAY
    function automatic logic [10:0] model_out(input int t, input bit en, input int L, input int B, input int C);
        int tt, k, bi, ph, lay;
        logic rd, strob, wb, layen, first, last, done;
        tt = L * B * (C + 2) + 1;
        if (t == 0) return 11'h020;
        rd = 1'b0; strob = 1'b0; wb = 1'b0; layen = 1'b0; done = 1'b0;
        if (t == tt) begin
            done  = en;
            first = (L == 1);
            last  = 1'b1;
        end else begin
            k     = t - 1;
            bi    = k / (C + 2);
            ph    = k % (C + 2);
            lay   = bi / B;
            rd    = (ph == 0);
            strob = (ph == 1);
            wb    = (ph == C + 1);
            layen = wb && ((bi % B) == B - 1);
            first = (lay == 0);
            last  = (lay == L - 1);
        end
        return {1'b1, done, strob & en, wb & en, layen & en, 1'b0,
                rd & en, wb & en, wb & en, first, last};
    endfunction

    task automatic step(input bit en, input bit st, input bit ab);
        logic [10:0] o, e;
        EN = en; START = st; ABORT = ab;
        #1;
        o = {BUSY, DONE, BUT_STROB, ADDR_EN, LAY_EN, ADDR_RST, RAM_EN_R, RAM_EN_WR, WR, FIRST_LAY, LAST_LAY};
        e = model_out(t_m, en, L0, B0, C0);
        if (o !== e) begin
            if (trace_err == 0) begin bad_cyc = cyc; bad_o = o; bad_e = e; end
            trace_err++;
        end
        if (BUT_STROB === 1'b1) cnt_strob++;
        if (ADDR_EN === 1'b1) cnt_addr++;
        if (WR === 1'b1) cnt_wr++;
        if (LAY_EN === 1'b1) cnt_lay++;
        if (!en && (BUT_STROB | ADDR_EN | LAY_EN | RAM_EN_R | RAM_EN_WR | WR | DONE) !== 1'b0) off_strobe++;
        if (DONE === 1'b1) begin done_seen = 1'b1; done_cyc = cyc; done_q.push_back(cyc); cnt_done++; end
        if ((cyc - run_a) >= 0 && (cyc - run_a) < 256) ll_hist[cyc - run_a] = LAST_LAY;
        @(posedge CLK);
        cyc++;
        if (ab && t_m != 0) t_m = 0;
        else if (en) begin
            if (t_m == 0) t_m = st ? 1 : 0;
            else if (t_m == T0) t_m = 0;
            else t_m++;
        end
        #1;
    endtask

    task automatic clear_stats();
        cnt_strob = 0; cnt_addr = 0; cnt_wr = 0; cnt_lay = 0; cnt_done = 0;
        off_strobe = 0; trace_err = 0; done_seen = 1'b0; done_cyc = -1;
        done_q.delete(); run_a = cyc;
    endtask

    task automatic run_full(input bit ab_at_start, output int lat);
        int a;
        a = cyc; run_a = a; done_seen = 1'b0;
        step(1'b1, 1'b1, ab_at_start);
        for (int i = 0; i < 300 && !done_seen; i++) step(1'b1, 1'b0, 1'b0);
        lat = done_seen ? (done_cyc - a) : -1;
    endtask

    task automatic test_reset();
        logic [10:0] o;
        RST = 1'b0; EN = 1'b1; START = 1'b1; ABORT = 1'b0;
        #1;
        o = {BUSY, DONE, BUT_STROB, ADDR_EN, LAY_EN, ADDR_RST, RAM_EN_R, RAM_EN_WR, WR, FIRST_LAY, LAST_LAY};
        n_tests++;
        if (o !== 11'h020) begin n_fail++; $display("FAIL reset_state: got %b required %b", o, 11'h020); end
        START = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        clear_stats();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (trace_err != 0) begin n_fail++; $display("FAIL idle_trace: %0d bad cycles got %b required %b", trace_err, bad_o, bad_e); end
    endtask

    task automatic test_full_run();
        int lat, ll_cnt;
        bit ll_tail;
        clear_stats();
        run_full(1'b0, lat);
        n_tests++; if (lat != 61) begin n_fail++; $display("FAIL run_latency: got %0d required 61", lat); end
        n_tests++; if (cnt_strob != 12) begin n_fail++; $display("FAIL run_but_strob: got %0d required 12", cnt_strob); end
        n_tests++; if (cnt_addr != 12) begin n_fail++; $display("FAIL run_addr_en: got %0d required 12", cnt_addr); end
        n_tests++; if (cnt_wr != 12) begin n_fail++; $display("FAIL run_wr: got %0d required 12", cnt_wr); end
        n_tests++; if (cnt_lay != 3) begin n_fail++; $display("FAIL run_lay_en: got %0d required 3", cnt_lay); end
        ll_cnt = 0; ll_tail = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            if (ll_hist[i] === 1'b1) ll_cnt++;
            if (i >= 41 && ll_hist[i] !== 1'b1) ll_tail = 1'b0;
        end
        n_tests++; if (ll_cnt != 20 || !ll_tail) begin n_fail++; $display("FAIL run_last_lay: got %0d cycles tail=%0d required 20 tail=1", ll_cnt, ll_tail); end
        n_tests++; if (trace_err != 0) begin n_fail++; $display("FAIL run_trace: %0d bad cycles, first at %0d got %b required %b", trace_err, bad_cyc, bad_o, bad_e); end
    endtask

    task automatic test_reset_mid_run();
        logic [10:0] o;
        int lat;
        clear_stats();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100 && t_m != 23; i++) step(1'b1, 1'b0, 1'b0);
        RST = 1'b0;
        #1;
        o = {BUSY, DONE, BUT_STROB, ADDR_EN, LAY_EN, ADDR_RST, RAM_EN_R, RAM_EN_WR, WR, FIRST_LAY, LAST_LAY};
        n_tests++; if (o !== 11'h020 || t_m != 23) begin n_fail++; $display("FAIL reset_mid_run: got %b (t=%0d) required %b (t=23)", o, t_m, 11'h020); end
        t_m = 0;
        cnt_done = 0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        RST = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        run_full(1'b0, lat);
        n_tests++; if (lat != 61) begin n_fail++; $display("FAIL reset_rerun_latency: got %0d required 61", lat); end
        n_tests++; if (cnt_done != 1) begin n_fail++; $display("FAIL reset_rerun_done: got %0d required 1", cnt_done); end
        n_tests++; if (trace_err != 0) begin n_fail++; $display("FAIL reset_trace: %0d bad cycles, first at %0d got %b required %b", trace_err, bad_cyc, bad_o, bad_e); end
    endtask

    task automatic test_en_stall();
        int a, lat;
        bit d1, d2;
        clear_stats();
        a = cyc; d1 = 1'b0; d2 = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 200 && !done_seen; i++) begin
            if (t_m == 3 && !d1) begin d1 = 1'b1; repeat (5) step(1'b0, 1'b0, 1'b0); end
            else if (t_m == 30 && !d2) begin d2 = 1'b1; repeat (5) step(1'b0, 1'b0, 1'b0); end
            else step(1'b1, 1'b0, 1'b0);
        end
        lat = done_seen ? (done_cyc - a) : -1;
        n_tests++; if (lat != 71) begin n_fail++; $display("FAIL stall_latency: got %0d required 71", lat); end
        n_tests++; if (cnt_strob != 12 || cnt_addr != 12 || cnt_lay != 3) begin n_fail++; $display("FAIL stall_counts: got %0d/%0d/%0d required 12/12/3", cnt_strob, cnt_addr, cnt_lay); end
        n_tests++; if (off_strobe != 0) begin n_fail++; $display("FAIL stall_strobe_while_off: got %0d required 0", off_strobe); end
        n_tests++; if (trace_err != 0) begin n_fail++; $display("FAIL stall_trace: %0d bad cycles, first at %0d got %b required %b", trace_err, bad_cyc, bad_o, bad_e); end
    endtask

    task automatic test_abort();
        logic [2:0] o;
        int lat;
        clear_stats();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100 && t_m != 53; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        EN = 1'b1; START = 1'b0; ABORT = 1'b0;
        #1;
        o = {BUSY, ADDR_RST, DONE};
        n_tests++; if (o !== 3'b010) begin n_fail++; $display("FAIL abort_idle: got %b required 010", o); end
        repeat (70) step(1'b1, 1'b0, 1'b0);
        n_tests++; if (cnt_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d required 0", cnt_done); end
        step(1'b1, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        #1;
        o = {BUSY, ADDR_RST, DONE};
        n_tests++; if (o !== 3'b010) begin n_fail++; $display("FAIL abort_en_low: got %b required 010", o); end
        run_full(1'b1, lat);
        n_tests++; if (lat != 61) begin n_fail++; $display("FAIL abort_rerun_latency: got %0d required 61", lat); end
        n_tests++; if (cnt_done != 1) begin n_fail++; $display("FAIL abort_rerun_done: got %0d required 1", cnt_done); end
        n_tests++; if (trace_err != 0) begin n_fail++; $display("FAIL abort_trace: %0d bad cycles, first at %0d got %b required %b", trace_err, bad_cyc, bad_o, bad_e); end
    endtask

    task automatic test_back_to_back();
        int a, lat;
        bit gaps_ok;
        clear_stats();
        a = cyc;
        repeat (200) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100 && t_m != 0; i++) step(1'b1, 1'b0, 1'b0);
        n_tests++; if (done_q.size() != 4) begin n_fail++; $display("FAIL b2b_done_count: got %0d required 4", done_q.size()); end
        if (done_q.size() >= 1) begin
            gaps_ok = (done_q[0] - a == 61);
            for (int i = 1; i < done_q.size(); i++) if (done_q[i] - done_q[i-1] != 62) gaps_ok = 1'b0;
            n_tests++; if (!gaps_ok) begin n_fail++; $display("FAIL b2b_spacing: first at %0d required 61, gaps required 62", done_q[0] - a); end
        end
        a = cyc; done_seen = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 200 && !done_seen; i++) step(1'b1, (t_m >= 1) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
        lat = done_seen ? (done_cyc - a) : -1;
        n_tests++; if (lat != 61) begin n_fail++; $display("FAIL busy_start_latency: got %0d required 61", lat); end
        n_tests++; if (trace_err != 0) begin n_fail++; $display("FAIL b2b_trace: %0d bad cycles, first at %0d got %b required %b", trace_err, bad_cyc, bad_o, bad_e); end
    endtask

    task automatic test_random_en();
        int en_cnt;
        bit en;
        for (int r = 0; r < 3; r++) begin
            clear_stats();
            en_cnt = 0;
            step(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 600 && !done_seen; i++) begin
                en = ($urandom_range(0, 3) != 0);
                step(en, (t_m >= 1) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
                if (en) en_cnt++;
            end
            n_tests++; if (en_cnt != 61) begin n_fail++; $display("FAIL rand_en_latency[%0d]: got %0d enabled cycles required 61", r, en_cnt); end
            n_tests++; if (cnt_strob != 12 || cnt_wr != 12 || cnt_lay != 3 || off_strobe != 0) begin
                n_fail++; $display("FAIL rand_en_counts[%0d]: got %0d/%0d/%0d off=%0d required 12/12/3 off=0", r, cnt_strob, cnt_wr, cnt_lay, off_strobe);
            end
            n_tests++; if (trace_err != 0) begin n_fail++; $display("FAIL rand_en_trace[%0d]: %0d bad cycles, first at %0d got %b required %b", r, trace_err, bad_cyc, bad_o, bad_e); end
        end
    endtask

    task automatic test_sweep();
        int a, tg;
        int t_sw[3];
        int lat_sw[3];
        logic [10:0] o, e;
        trace_err = 0;
        for (int g = 0; g < 3; g++) begin t_sw[g] = 0; lat_sw[g] = -1; end
        a = cyc;
        for (int i = 0; i < 520; i++) begin
            start_sw = (i == 0);
            #1;
            for (int g = 0; g < 3; g++) begin
                o = {sw_busy[g], sw_done[g], sw_strob[g], sw_addr_en[g], sw_lay_en[g], sw_addr_rst[g],
                     sw_ram_r[g], sw_ram_wr[g], sw_wr[g], sw_first[g], sw_last[g]};
                e = model_out(t_sw[g], 1'b1, 5, 16, sw_c(g));
                if (o !== e) begin
                    if (trace_err == 0) begin bad_cyc = cyc; bad_o = o; bad_e = e; end
                    trace_err++;
                end
                if (sw_done[g] === 1'b1 && lat_sw[g] < 0) lat_sw[g] = cyc - a;
            end
            @(posedge CLK);
            cyc++;
            for (int g = 0; g < 3; g++) begin
                tg = 80 * (sw_c(g) + 2) + 1;
                if (t_sw[g] == 0) t_sw[g] = start_sw ? 1 : 0;
                else if (t_sw[g] == tg) t_sw[g] = 0;
                else t_sw[g]++;
            end
            #1;
        end
        start_sw = 1'b0;
        for (int g = 0; g < 3; g++) begin
            tg = 80 * (sw_c(g) + 2) + 1;
            n_tests++; if (lat_sw[g] != tg) begin n_fail++; $display("FAIL sweep_latency_c%0d: got %0d required %0d", sw_c(g), lat_sw[g], tg); end
        end
        n_tests++; if (trace_err != 0) begin n_fail++; $display("FAIL sweep_trace: %0d bad cycles, first at %0d got %b required %b", trace_err, bad_cyc, bad_o, bad_e); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; t_m = 0; run_a = 0;
        RST = 1'b0; EN = 1'b0; START = 1'b0; ABORT = 1'b0; start_sw = 1'b0;
        clear_stats();
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_full_run();
        test_reset_mid_run();
        test_en_stall();
        test_abort();
        test_back_to_back();
        test_random_en();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
